fir_tap_feeder: RTL and testbench
=================================

// Module: fir_tap_feeder
// PURPOSE
//  Upstream stage of the FIR MAC: accepts input samples into a 71-entry ring, owns a loadable
//  sign-magnitude coefficient table, and per sample drives one MAC run (enable/address/x/h/sign),
//  then captures the MAC accumulator as the filter output. Sits between sample source and MAC.
// PARAMETERS
//  NTAPS    71    taps per run; MAC addresses 0..NTAPS-1 are served
//  SW       16    input sample width, signed two's complement
//  TIMEOUT  255   max cycles in RUN waiting for mac_over before abort
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  sample_in    in   SW  new sample, signed
//  sample_vld   in   1   1-cycle strobe, sample_in valid
//  coef_we      in   1   coefficient write strobe
//  coef_addr    in   7   coefficient index 0..NTAPS-1
//  coef_data    in   17  {sign, magnitude[15:0]}
//  mac_enable   out  1   MAC run enable
//  mac_address  in   7   MAC current tap index
//  mac_x        out  32  |sample| of tap at mac_address, zero-extended
//  mac_h        out  16  |coef| at mac_address
//  mac_sign     out  1   sample sign XOR coef sign at mac_address
//  mac_over     in   1   MAC run-complete pulse
//  mac_y        in   32  MAC accumulator
//  result       out  32  filter output, signed
//  result_vld   out  1   1-cycle strobe, result updated
//  busy         out  1   state != IDLE
//  overrun      out  1   sticky: sample dropped
//  timeout_err  out  1   sticky: run aborted on timeout
// BEHAVIOUR
//  Reset: all outputs 0; ring, coef table, wr_ptr, pending, timer cleared; state IDLE.
//  Ring: entry = {sign, mag[31:0]}; mag = |sample_in| (-2^(SW-1) -> 2^(SW-1)). wr_ptr wraps NTAPS-1 -> 0.
//  Tap k (k=0 newest) = ring[(wr_ptr-1-k) mod NTAPS]. Unwritten entries read 0.
//  mac_x/mac_h/mac_sign: combinational from mac_address and registered storage (same-cycle);
//   mac_address >= NTAPS -> all 0.
//  Pending: sample_vld latches sample into 1-deep pending reg; if pending already full, new
//   sample dropped, overrun<=1. sample_vld and pending-drain same cycle: new sample kept.
//  FSM:
//   IDLE : pending full -> write ring[wr_ptr], wr_ptr++, clear pending -> LOAD.
//   LOAD : mac_enable=0 (guarantees MAC sees a rising edge) -> RUN, timer<=0.
//   RUN  : mac_enable=1; ring/coef frozen. mac_over=1 -> result<=mac_y -> DONE.
//          timer==TIMEOUT -> timeout_err<=1, result unchanged -> DONE.
//   DONE : mac_enable=0; result_vld=1 only if entered via mac_over -> IDLE.
//  Latency sample_vld (idle) -> mac_enable high: 3 cycles (pending, IDLE, LOAD).
//  Coef writes: applied in IDLE/LOAD only; in RUN/DONE ignored (table unchanged).
//   coef_addr >= NTAPS ignored.
//  Sticky flags clear only on reset. Reset mid-run: mac_enable drops asynchronously, no result_vld.
// STRUCTURE
//  Package fir_pkg: NTAPS, SW, coef_t {sign, mag[15:0]}, sample_t {sign, mag[31:0]}, state enum.
//  Sub-module fir_ring_buf: ring storage, wr_ptr, tap-index mod-NTAPS read mux.
//  FSM, pending reg, coef table, timer in top.
// TESTING
//  Impulse: coefs h[k]=k+1 all positive; sample 1 then 0s -> results 1,2,3,... per sample.
//  Signs: coef[0]=-3, sample -5 (ring empty) -> mac_sign=0, mac_x=5, mac_h=3 at addr 0; result 15.
//  Wrap: 75 samples of value n -> tap 0 = 75, tap 70 = 5; wr_ptr wraps to 4.
//  Overrun: 3 sample_vld while RUN -> one pending kept, overrun=1, next run uses 2nd sample.
//  Timeout: hold mac_over=0 -> timeout_err=1 after TIMEOUT+1 RUN cycles, no result_vld, IDLE.
//  Coef write during RUN ignored; reset asserted in RUN -> mac_enable=0, outputs 0 immediately.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap feeder.
// Sample/coefficient sign-magnitude formats and FSM states.
package fir_pkg;
  localparam int NTAPS   = 71;
  localparam int SW      = 16;
  localparam int TIMEOUT = 255;
  localparam int AW      = 7;

  localparam logic [AW-1:0] NTAPS_A   = AW'(NTAPS);
  localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);
  localparam logic [7:0]    TIMEOUT_T = 8'(TIMEOUT);

  typedef struct packed {
    logic        sign;
    logic [15:0] mag;
  } coef_t;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_e;

  // Two's complement to sign-magnitude; -2^(SW-1) maps to 2^(SW-1).
  function automatic sample_t to_sm(input logic [SW-1:0] s);
    sample_t r;
    logic [SW-1:0] a;
    a = s[SW-1] ? -s : s;
    r.sign = s[SW-1];
    r.mag  = {{(32-SW){1'b0}}, a};
    return r;
  endfunction
endpackage

// File: rtl/fir_ring_buf.sv
// Sample ring: NTAPS sign-magnitude entries, wrapping write pointer.
// Ports: wr_en/wr_data write at wr_ptr; rd_tap (0 = newest) -> rd_data.
module fir_ring_buf
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  sample_t       wr_data,
  input  logic [AW-1:0] rd_tap,
  output sample_t       rd_data
);
  sample_t       ring_q [NTAPS];
  sample_t       ring_d [NTAPS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   sum;
  logic [AW:0]   idx;

  always_comb begin
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      ring_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == LAST_TAP) ? '0
               : wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) ring_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      ring_q   <= ring_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // (wr_ptr - 1 - tap) mod NTAPS, kept non-negative by adding NTAPS first.
  always_comb begin
    sum = {1'b0, wr_ptr_q} + {1'b0, LAST_TAP}
        - {1'b0, rd_tap};
    idx = (sum >= {1'b0, NTAPS_A})
        ? sum - {1'b0, NTAPS_A} : sum;
    rd_data = '0;
    if (rd_tap < NTAPS_A) rd_data = ring_q[idx[AW-1:0]];
  end
endmodule

// File: rtl/fir_tap_feeder.sv
// FIR MAC feeder: pending sample reg, ring, coef table, run FSM.
// Ports: sample/coef inputs, MAC handshake (enable/address/x/h/sign/over/y), result + status.
module fir_tap_feeder
  import fir_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [SW-1:0] sample_in,
  input  logic          sample_vld,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [16:0]   coef_data,
  output logic          mac_enable,
  input  logic [AW-1:0] mac_address,
  output logic [31:0]   mac_x,
  output logic [15:0]   mac_h,
  output logic          mac_sign,
  input  logic          mac_over,
  input  logic [31:0]   mac_y,
  output logic [31:0]   result,
  output logic          result_vld,
  output logic          busy,
  output logic          overrun,
  output logic          timeout_err
);
  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  sample_t     pdat_q, pdat_d;
  coef_t       coef_q [NTAPS];
  coef_t       coef_d [NTAPS];
  logic [7:0]  timer_q, timer_d;
  logic        mac_en_q, mac_en_d;
  logic [31:0] result_q, result_d;
  logic        rvld_q, rvld_d;
  logic        overrun_q, overrun_d;
  logic        tout_q, tout_d;
  logic        ring_we;
  logic        drain;
  logic        coef_open;
  sample_t     tap;

  fir_ring_buf u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ring_we),
    .wr_data (pdat_q),
    .rd_tap  (mac_address),
    .rd_data (tap)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pdat_d    = pdat_q;
    coef_d    = coef_q;
    timer_d   = timer_q;
    mac_en_d  = mac_en_q;
    result_d  = result_q;
    rvld_d    = 1'b0;
    overrun_d = overrun_q;
    tout_d    = tout_q;
    ring_we   = 1'b0;
    drain     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          ring_we = 1'b1;
          drain   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mac_en_d = 1'b1;
        timer_d  = '0;
        state_d  = RUN;
      end
      RUN: begin
        if (mac_over) begin
          result_d = mac_y;
          rvld_d   = 1'b1;
          mac_en_d = 1'b0;
          state_d  = DONE;
        end else if (timer_q == TIMEOUT_T) begin
          tout_d   = 1'b1;
          mac_en_d = 1'b0;
          state_d  = DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new strobe in the drain cycle refills the slot.
    if (drain) pend_d = 1'b0;
    if (sample_vld) begin
      if (!pend_q || drain) begin
        pend_d = 1'b1;
        pdat_d = to_sm(sample_in);
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Table is frozen while the MAC may be reading it.
    coef_open = (state_q == IDLE) || (state_q == LOAD);
    if (coef_we && coef_open && (coef_addr < NTAPS_A))
      coef_d[coef_addr] = coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      pdat_q    <= '0;
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
      timer_q   <= '0;
      mac_en_q  <= 1'b0;
      result_q  <= '0;
      rvld_q    <= 1'b0;
      overrun_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pdat_q    <= pdat_d;
      coef_q    <= coef_d;
      timer_q   <= timer_d;
      mac_en_q  <= mac_en_d;
      result_q  <= result_d;
      rvld_q    <= rvld_d;
      overrun_q <= overrun_d;
      tout_q    <= tout_d;
    end
  end

  always_comb begin
    mac_x    = '0;
    mac_h    = '0;
    mac_sign = 1'b0;
    if (mac_address < NTAPS_A) begin
      mac_x    = tap.mag;
      mac_h    = coef_q[mac_address].mag;
      mac_sign = tap.sign ^ coef_q[mac_address].sign;
    end
  end

  assign mac_enable  = mac_en_q;
  assign result      = result_q;
  assign result_vld  = rvld_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = tout_q;
endmodule

// File: tb/tb_fir_tap_feeder.sv
// Bench for fir_tap_feeder: emulated MAC, convolution reference model.
// Table-driven impulse vectors, directed corner sequences, random runs.
`timescale 1ns/1ps
module tb_fir_tap_feeder;
  import fir_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   sample_in = '0;
  logic          sample_vld = 1'b0;
  logic          coef_we = 1'b0;
  logic [6:0]    coef_addr = '0;
  logic [16:0]   coef_data = '0;
  logic          mac_enable;
  logic [6:0]    mac_address;
  logic [31:0]   mac_x;
  logic [15:0]   mac_h;
  logic          mac_sign;
  logic          mac_over;
  logic [31:0]   mac_y;
  logic [31:0]   result;
  logic          result_vld;
  logic          busy;
  logic          overrun;
  logic          timeout_err;

  always #5 clk = ~clk;

  fir_tap_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_vld  (sample_vld),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .mac_enable  (mac_enable),
    .mac_address (mac_address),
    .mac_x       (mac_x),
    .mac_h       (mac_h),
    .mac_sign    (mac_sign),
    .mac_over    (mac_over),
    .mac_y       (mac_y),
    .result      (result),
    .result_vld  (result_vld),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference: sample history (newest first) and signed coefficients.
  int hist[$];
  int model_h[NTAPS];

  logic        mac_hang = 1'b0;
  logic [6:0]  idle_addr = '0;
  logic [31:0] cap_x0, cap_x70, cap_h0;
  logic        cap_s0;

  // Emulated MAC: one tap per cycle, then a mac_over pulse.
  initial begin
    logic [31:0] acc, p;
    bit aborted;
    mac_over = 1'b0;
    mac_y = '0;
    mac_address = '0;
    forever begin
      @(negedge clk);
      mac_address = idle_addr;
      if (mac_enable && !mac_hang) begin
        acc = '0;
        aborted = 1'b0;
        for (int a = 0; a < NTAPS; a++) begin
          mac_address = 7'(a);
          #1;
          p = mac_x * {16'd0, mac_h};
          acc = mac_sign ? acc - p : acc + p;
          if (a == 0) begin
            cap_x0 = mac_x;
            cap_h0 = {16'd0, mac_h};
            cap_s0 = mac_sign;
          end
          if (a == NTAPS - 1) cap_x70 = mac_x;
          @(negedge clk);
          if (!mac_enable) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          mac_y = acc;
          mac_over = 1'b1;
          @(negedge clk);
          mac_over = 1'b0;
        end
        mac_address = idle_addr;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_y();
    logic [31:0] acc = '0;
    for (int k = 0; k < hist.size(); k++)
      acc = acc + 32'(hist[k] * model_h[k]);
    return acc;
  endfunction

  function automatic void push_sample(input int s);
    hist.push_front(s);
    if (hist.size() > NTAPS) void'(hist.pop_back());
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sample_vld = 1'b0;
    coef_we = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    hist.delete();
    foreach (model_h[i]) model_h[i] = 0;
  endtask

  task automatic write_coef(input int addr, input bit sgn,
                            input int mag, input bit applied);
    coef_we = 1'b1;
    coef_addr = 7'(addr);
    coef_data = {sgn, 16'(mag)};
    tick(1);
    coef_we = 1'b0;
    if (applied && addr < NTAPS) model_h[addr] = sgn ? -mag : mag;
  endtask

  task automatic send(input int s);
    sample_vld = 1'b1;
    sample_in = 16'(s);
    tick(1);
    sample_vld = 1'b0;
    push_sample(s);
  endtask

  task automatic wait_enable(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mac_enable) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    if (!seen) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: mac_enable never rose", name);
    end
  endtask

  // Waits for result_vld, compares, then steps into IDLE.
  task automatic expect_result(input string name, input logic [31:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick(1);
      if (result_vld) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      ncmp++;
      nfail++;
      $display("FAIL %s: no result_vld, expected %0h", name, exp);
    end else begin
      chk(name, result, exp);
    end
    tick(1);
  endtask

  typedef struct {
    int          s;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [31:0] ea, eb;
    logic [15:0] r;
    int s, cnt;
    bit rv_seen;

    tbl[0] = '{1, 32'd1};
    tbl[1] = '{0, 32'd2};
    tbl[2] = '{0, 32'd3};
    tbl[3] = '{0, 32'd4};
    tbl[4] = '{0, 32'd5};
    tbl[5] = '{0, 32'd6};
    tbl[6] = '{0, 32'd7};
    tbl[7] = '{0, 32'd8};

    do_reset();
    chk("rst_mac_enable", {31'd0, mac_enable}, 0);
    chk("rst_result", result, 0);
    chk("rst_result_vld", {31'd0, result_vld}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_overrun", {31'd0, overrun}, 0);
    chk("rst_timeout", {31'd0, timeout_err}, 0);
    chk("rst_mac_x", mac_x, 0);
    chk("rst_mac_h", {16'd0, mac_h}, 0);

    // Impulse response with h[k] = k+1.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1'b0, k + 1, 1'b1);
    foreach (tbl[i]) begin
      send(tbl[i].s);
      expect_result($sformatf("impulse_%0d", i), tbl[i].exp);
    end

    // Tap 7 is the impulse; addresses past the last tap read zero.
    idle_addr = 7'd7;
    tick(1);
    #1;
    chk("tap7_x", mac_x, 32'd1);
    chk("tap7_h", {16'd0, mac_h}, 32'd8);
    idle_addr = 7'd100;
    tick(1);
    #1;
    chk("oob_x", mac_x, 0);
    chk("oob_h", {16'd0, mac_h}, 0);
    chk("oob_sign", {31'd0, mac_sign}, 0);
    idle_addr = 7'd0;

    // Signs: coef -3, sample -5.
    do_reset();
    write_coef(0, 1'b1, 3, 1'b1);
    send(-5);
    expect_result("sign_result", 32'd15);
    chk("sign_x0", cap_x0, 32'd5);
    chk("sign_h0", cap_h0, 32'd3);
    chk("sign_s0", {31'd0, cap_s0}, 0);

    // Coefficient write during RUN is ignored.
    write_coef(0, 1'b0, 1, 1'b1);
    send(7);
    ea = model_y();
    wait_enable("coef_run_en");
    write_coef(0, 1'b0, 100, 1'b0);
    expect_result("coef_run_1", ea);
    send(2);
    expect_result("coef_run_2", model_y());

    // Strobe in the drain cycle is kept, not dropped.
    send(3);
    ea = model_y();
    send(4);
    eb = model_y();
    expect_result("drain_a", ea);
    expect_result("drain_b", eb);
    chk("drain_no_overrun", {31'd0, overrun}, 0);

    // Overrun: three strobes during RUN, only the first survives.
    send(11);
    ea = model_y();
    wait_enable("ovr_en");
    sample_vld = 1'b1;
    sample_in = 16'd22;
    tick(1);
    sample_in = 16'd33;
    tick(1);
    sample_in = 16'd44;
    tick(1);
    sample_vld = 1'b0;
    push_sample(22);
    eb = model_y();
    expect_result("ovr_a", ea);
    expect_result("ovr_b", eb);
    chk("ovr_flag", {31'd0, overrun}, 1);

    // Timeout: MAC never answers.
    mac_hang = 1'b1;
    send(9);
    wait_enable("to_en");
    cnt = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (result_vld) rv_seen = 1'b1;
      if (!mac_enable) break;
      cnt++;
      tick(1);
    end
    for (int i = 0; i < 5; i++) begin
      if (result_vld) rv_seen = 1'b1;
      if (!busy) break;
      tick(1);
    end
    chk("to_run_cycles", cnt, TIMEOUT + 1);
    chk("to_flag", {31'd0, timeout_err}, 1);
    chk("to_no_rvld", {31'd0, rv_seen}, 0);
    chk("to_idle", {31'd0, busy}, 0);
    mac_hang = 1'b0;

    // Reset mid-run.
    send(5);
    wait_enable("rst_run_en");
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstrun_enable", {31'd0, mac_enable}, 0);
    chk("rstrun_busy", {31'd0, busy}, 0);
    chk("rstrun_result", result, 0);
    chk("rstrun_sticky", {30'd0, overrun, timeout_err}, 0);
    tick(2);
    rst_n = 1'b1;
    hist.delete();
    foreach (model_h[i]) model_h[i] = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (result_vld) rv_seen = 1'b1;
    end
    chk("rstrun_no_rvld", {31'd0, rv_seen}, 0);

    // Random coefficients and samples against the reference.
    for (int k = 0; k < NTAPS; k++)
      write_coef(k, 1'($urandom), int'($urandom_range(0, 65535)), 1'b1);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0)
        write_coef(int'($urandom_range(0, 90)), 1'($urandom),
                   int'($urandom_range(0, 65535)), 1'b1);
      r = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r = 16'h8000;
      s = int'($signed(r));
      send(s);
      ea = model_y();
      if ($urandom_range(0, 2) == 0) begin
        wait_enable("rand_en");
        write_coef(int'($urandom_range(0, 70)), 1'($urandom),
                   int'($urandom_range(0, 65535)), 1'b0);
      end
      expect_result($sformatf("rand_%0d", n), ea);
    end

    // Wrap: 75 samples of value n.
    for (int n = 1; n <= 75; n++) begin
      send(n);
      expect_result($sformatf("wrap_%0d", n), model_y());
    end
    chk("wrap_tap0", cap_x0, 32'd75);
    chk("wrap_tap70", cap_x70, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
